// File: rtl/sensor_tx_gen.sv
// Purpose : sensor emulator driving vvalid/hvalid/din framing with blanking and register-selected test patterns.
// Latency : 1 cycle from the counters to the pins; pixel (0,0) appears one edge after en=1 is sampled in IDLE.
// Backpressure: none; free-running source once started, stops only at a frame boundary when en is low.
//
// Ports:
//   clk, rst_b               pixel clock, asynchronous active-low reset
//   en                       run request; dropping it lets the current frame finish
//   reg_wea/addra/wdata      register write port (BASE_ADDR+0 pattern select, BASE_ADDR+1 constant)
//   vvalid, hvalid, dout     registered pixel stream; dout is 0 outside hvalid
//   frame_done               one-cycle pulse aligned with the last cycle of each frame
//
// Build option: define SENSOR_TX_PRBS_EN to build the 16-bit LFSR used by pattern 3
// (DW must then be <= 16). Without it pattern 3 is the horizontal ramp of pattern 0.
// DW, RD and the counter widths are assumed to fit in 32 bits.

module sensor_tx_gen #(
    parameter int             DW        = 8,
    parameter int             RW        = 32,
    parameter int             RD        = 8,
    parameter int             H_ACT     = 1920,
    parameter int             H_BLANK   = 280,
    parameter int             V_ACT     = 1080,
    parameter int             V_BLANK   = 45,
    parameter logic [RW-1:0]  BASE_ADDR = 32'h43C2_0000
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          en,
    input  logic          reg_wea,
    input  logic [RW-1:0] reg_addra,
    input  logic [RD-1:0] reg_wdata,
    output logic          vvalid,
    output logic          hvalid,
    output logic [DW-1:0] dout,
    output logic          frame_done
);

    localparam int H_TOT = H_ACT + H_BLANK;
    localparam int V_TOT = V_ACT + V_BLANK;
    localparam int HW    = (H_TOT > 1) ? $clog2(H_TOT) : 1;
    localparam int VW    = (V_TOT > 1) ? $clog2(V_TOT) : 1;
    // One spare bit so hcnt+vcnt never overflows before reduction to DW.
    localparam int CW    = ((HW > VW) ? HW : VW) + 1;

    localparam logic [HW-1:0] H_MAX   = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_MAX   = VW'(V_TOT - 1);
    localparam logic [HW-1:0] H_ACT_C = HW'(H_ACT);
    localparam logic [VW-1:0] V_ACT_C = VW'(V_ACT);

    localparam logic [RW-1:0] ADDR_SEL = BASE_ADDR;
    localparam logic [RW-1:0] ADDR_CST = BASE_ADDR + RW'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] hcnt, hcnt_nxt;
    logic [VW-1:0] vcnt, vcnt_nxt;

    logic          frame_start;   // counters are (0,0) after this edge; shadows load here
    logic          h_end;
    logic          frame_end;

    logic [1:0]    sel_reg, sel_shd, sel_nxt;
    logic [RD-1:0] cst_reg, cst_shd, cst_nxt;

    logic          vvalid_nxt;
    logic          hvalid_nxt;
    logic          frame_done_nxt;
    logic [DW-1:0] pix;
    logic [DW-1:0] dout_nxt;

`ifdef SENSOR_TX_PRBS_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    logic [15:0] lfsr;
    logic        lfsr_fb;
`endif

    // ------------------------------------------------------------------
    // Register write decode. A write landing on the frame-start edge must
    // reach the shadow, so the shadows load from the post-write value.
    // ------------------------------------------------------------------
    always_comb begin
        sel_nxt = sel_reg;
        cst_nxt = cst_reg;
        if (reg_wea && (reg_addra == ADDR_SEL)) begin
            sel_nxt = reg_wdata[1:0];
        end
        if (reg_wea && (reg_addra == ADDR_CST)) begin
            cst_nxt = reg_wdata;
        end
    end

    // ------------------------------------------------------------------
    // FSM and raster counters: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        hcnt_nxt    = hcnt;
        vcnt_nxt    = vcnt;
        frame_start = 1'b0;
        h_end       = (hcnt == H_MAX);
        frame_end   = h_end && (vcnt == V_MAX);

        unique case (state)
            IDLE: begin
                hcnt_nxt = '0;
                vcnt_nxt = '0;
                if (en) begin
                    state_nxt   = RUN;
                    frame_start = 1'b1;
                end
            end
            RUN: begin
                if (h_end) begin
                    hcnt_nxt = '0;
                    vcnt_nxt = (vcnt == V_MAX) ? '0 : vcnt + VW'(1);
                end else begin
                    hcnt_nxt = hcnt + HW'(1);
                end
                // en is only honoured at the frame wrap, so a stop request
                // never truncates the frame in flight.
                if (frame_end) begin
                    if (en) begin
                        frame_start = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                hcnt_nxt  = '0;
                vcnt_nxt  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pixel generation from the current counters; registered below.
    // ------------------------------------------------------------------
    always_comb begin
        vvalid_nxt     = (state == RUN) && (vcnt < V_ACT_C);
        hvalid_nxt     = vvalid_nxt && (hcnt < H_ACT_C);
        frame_done_nxt = (state == RUN) && frame_end;

        unique case (sel_shd)
            2'd0:    pix = DW'(hcnt);
            2'd1:    pix = DW'(CW'(hcnt) + CW'(vcnt));
            2'd2:    pix = DW'(cst_shd);
`ifdef SENSOR_TX_PRBS_EN
            2'd3:    pix = DW'(lfsr);
`else
            2'd3:    pix = DW'(hcnt);
`endif
            default: pix = DW'(hcnt);
        endcase

        dout_nxt = hvalid_nxt ? pix : '0;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Counters, registers, shadows and output pins
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hcnt       <= '0;
            vcnt       <= '0;
            sel_reg    <= '0;
            cst_reg    <= '0;
            sel_shd    <= '0;
            cst_shd    <= '0;
            vvalid     <= 1'b0;
            hvalid     <= 1'b0;
            dout       <= '0;
            frame_done <= 1'b0;
        end else begin
            hcnt       <= hcnt_nxt;
            vcnt       <= vcnt_nxt;
            sel_reg    <= sel_nxt;
            cst_reg    <= cst_nxt;
            if (frame_start) begin
                sel_shd <= sel_nxt;
                cst_shd <= cst_nxt;
            end
            vvalid     <= vvalid_nxt;
            hvalid     <= hvalid_nxt;
            dout       <= dout_nxt;
            frame_done <= frame_done_nxt;
        end
    end

`ifdef SENSOR_TX_PRBS_EN
    // x^16 + x^14 + x^13 + x^11 + 1, shifting right; feedback enters bit 15.
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    // Frame start never coincides with an active pixel (blanking >= 1),
    // so reseed and advance are mutually exclusive.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            lfsr <= LFSR_SEED;
        end else if (frame_start) begin
            lfsr <= LFSR_SEED;
        end else if (hvalid_nxt) begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
        end
    end
`endif

endmodule

// File: tb/tb_sensor_tx_gen.sv
module tb_sensor_tx_gen;

    localparam int          HA   = 8;
    localparam int          HB   = 4;
    localparam int          VA   = 3;
    localparam int          VB   = 2;
    localparam int          HT   = HA + HB;
    localparam int          FT   = HT * (VA + VB);
    localparam logic [31:0] BASE = 32'h43C2_0000;

    logic        clk       = 1'b0;
    logic        rst_b     = 1'b0;
    logic        en        = 1'b0;
    logic        reg_wea   = 1'b0;
    logic [31:0] reg_addra = '0;
    logic [7:0]  reg_wdata = '0;
    logic        vvalid;
    logic        hvalid;
    logic [7:0]  dout;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] ref_lfsr = 16'hACE1;

    sensor_tx_gen #(
        .DW(8), .RW(32), .RD(8),
        .H_ACT(HA), .H_BLANK(HB), .V_ACT(VA), .V_BLANK(VB),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst_b(rst_b), .en(en),
        .reg_wea(reg_wea), .reg_addra(reg_addra), .reg_wdata(reg_wdata),
        .vvalid(vvalid), .hvalid(hvalid), .dout(dout), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] cst;
        int         k;
        logic       vv;
        logic       hv;
        logic [7:0] d;
        logic       fd;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] prbs_next(input logic [15:0] s);
        logic b;
        b = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {b, s[15:1]};
    endfunction

    // Advance one cycle and compare against frame cycle k of pattern sel.
    task automatic step(input int sel, input logic [7:0] cst, input int k);
        int         line;
        int         px;
        logic       evv;
        logic       ehv;
        logic [7:0] ed;
        tick();
        line = k / HT;
        px   = k % HT;
        evv  = (line < VA);
        ehv  = evv && (px < HA);
        if (k == 0) ref_lfsr = 16'hACE1;
        case (sel)
            1:       ed = 8'(px + line);
            2:       ed = cst;
`ifdef SENSOR_TX_PRBS_EN
            3:       ed = ref_lfsr[7:0];
`endif
            default: ed = 8'(px);
        endcase
        if (!ehv) ed = 8'h00;
        chk($sformatf("s%0d k%0d vvalid", sel, k), {31'd0, vvalid}, {31'd0, evv});
        chk($sformatf("s%0d k%0d hvalid", sel, k), {31'd0, hvalid}, {31'd0, ehv});
        chk($sformatf("s%0d k%0d dout", sel, k), {24'd0, dout}, {24'd0, ed});
        chk($sformatf("s%0d k%0d frame_done", sel, k), {31'd0, frame_done}, {31'd0, (k == FT - 1)});
        if (ehv) ref_lfsr = prbs_next(ref_lfsr);
    endtask

    task automatic frame(input int sel, input logic [7:0] cst, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) step(sel, cst, k);
    endtask

    // Present a write to be sampled on the next edge (caller ticks).
    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        reg_wea   = 1'b1;
        reg_addra = a;
        reg_wdata = d;
    endtask

    task automatic wr_idle(input logic [31:0] a, input logic [7:0] d);
        wr(a, d);
        tick();
        reg_wea = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        chk(name, {21'd0, vvalid, hvalid, dout, frame_done}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{2'd0, 8'h00,  0, 1'b1, 1'b1, 8'h00, 1'b0};
        vecs[1] = '{2'd0, 8'h00,  7, 1'b1, 1'b1, 8'h07, 1'b0};
        vecs[2] = '{2'd0, 8'h00,  8, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{2'd1, 8'h00, 27, 1'b1, 1'b1, 8'h05, 1'b0};
        vecs[4] = '{2'd1, 8'h00, 19, 1'b1, 1'b1, 8'h08, 1'b0};
        vecs[5] = '{2'd2, 8'h3C, 30, 1'b1, 1'b1, 8'h3C, 1'b0};
        vecs[6] = '{2'd2, 8'h3C, 36, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[7] = '{2'd0, 8'h00, 59, 1'b0, 1'b0, 8'h00, 1'b1};
`ifdef SENSOR_TX_PRBS_EN
        vecs[8] = '{2'd3, 8'h00,  0, 1'b1, 1'b1, 8'hE1, 1'b0};
        vecs[9] = '{2'd3, 8'h00,  1, 1'b1, 1'b1, 8'h70, 1'b0};
`else
        vecs[8] = '{2'd3, 8'h00,  0, 1'b1, 1'b1, 8'h00, 1'b0};
        vecs[9] = '{2'd3, 8'h00,  1, 1'b1, 1'b1, 8'h01, 1'b0};
`endif

        // Reset held, then released with en low for 100 cycles.
        repeat (3) tick();
        chk_zero("in_reset outputs");
        rst_b = 1'b1;
        for (int i = 0; i < 100; i++) chk_zero_cycle();

        // Table: program while idle, run exactly one frame, spot-check cycle k.
        for (int i = 0; i < 10; i++) begin
            wr_idle(BASE, {6'd0, vecs[i].sel});
            wr_idle(BASE + 32'd1, vecs[i].cst);
            en = 1'b1;
            tick();
            en = 1'b0;
            repeat (vecs[i].k + 1) tick();
            chk($sformatf("vec%0d vvalid", i), {31'd0, vvalid}, {31'd0, vecs[i].vv});
            chk($sformatf("vec%0d hvalid", i), {31'd0, hvalid}, {31'd0, vecs[i].hv});
            chk($sformatf("vec%0d dout", i), {24'd0, dout}, {24'd0, vecs[i].d});
            chk($sformatf("vec%0d frame_done", i), {31'd0, frame_done}, {31'd0, vecs[i].fd});
            repeat (FT - 1 - vecs[i].k) tick();
            tick();
            chk_zero($sformatf("vec%0d stopped", i));
        end

        // Continuous ramp: 1-cycle start latency, back-to-back frames.
        wr_idle(BASE, 8'd0);
        en = 1'b1;
        tick();
        chk_zero("start latency");
        frame(0, 8'h00, 0, FT - 1);

        // Mid-frame writes must not disturb the current frame.
        frame(0, 8'h00, 0, 9);
        wr(BASE + 32'd1, 8'hA5);
        step(0, 8'h00, 10);
        wr(BASE, 8'd2);
        step(0, 8'h00, 11);
        reg_wea = 1'b0;
        frame(0, 8'h00, 12, FT - 1);

        // Constant frame; unmatched addresses ignored; select 1 queued.
        frame(2, 8'hA5, 0, 29);
        wr(BASE + 32'd2, 8'h03);
        step(2, 8'hA5, 30);
        wr(32'h43C3_0000, 8'h03);
        step(2, 8'hA5, 31);
        wr(BASE, 8'd1);
        step(2, 8'hA5, 32);
        reg_wea = 1'b0;
        frame(2, 8'hA5, 33, FT - 1);

        // Pattern 1; select 3 written on the frame-start edge itself.
        frame(1, 8'hA5, 0, FT - 2);
        wr(BASE, 8'd3);
        step(1, 8'hA5, FT - 1);
        reg_wea = 1'b0;

        // Pattern 3 twice (reseed), en dropped on vvalid's 10th cycle.
        frame(3, 8'hA5, 0, FT - 1);
        frame(3, 8'hA5, 0, 9);
        en = 1'b0;
        frame(3, 8'hA5, 10, FT - 1);
        for (int i = 0; i < 20; i++) chk_zero_cycle();

        // Asynchronous reset mid-frame.
        en = 1'b1;
        tick();
        frame(3, 8'hA5, 0, 14);
        #2;
        rst_b = 1'b0;
        #1;
        chk_zero("async reset immediate");
        en = 1'b0;
        repeat (3) tick();
        chk_zero("held in reset");
        rst_b = 1'b1;
        for (int i = 0; i < 5; i++) chk_zero_cycle();

        // Registers cleared by reset: ramp again.
        en = 1'b1;
        tick();
        en = 1'b0;
        frame(0, 8'h00, 0, FT - 1);
        tick();
        chk_zero("final stop");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    task automatic chk_zero_cycle();
        tick();
        chk_zero("idle outputs");
    endtask

endmodule

// File: doc/sensor_tx_gen.md
# sensor_tx_gen

Synthesizable sensor emulator: the transmitting end of the `vvalid`/`hvalid`/`din` pixel protocol that `line7_buffer` receives. It generates frame and line timing with blanking and fills active pixels from a register-selected test pattern. It replaces the behavioural stimulus in benches and serves as an on-chip test source ahead of the line buffer. Pattern selection uses the same 32-bit-address register write port as the rest of the pipeline.

## Interface
- DW, 8, pixel width.
- RW, 32, register address width.
- RD, 8, register data width.
- H_ACT, 1920, active pixels per line.
- H_BLANK, 280, horizontal blanking cycles per line (≥1).
- V_ACT, 1080, active lines per frame.
- V_BLANK, 45, blanking lines per frame (≥1).
- BASE_ADDR, 32'h43C2_0000, register base address.

Ports:
- clk  in  1  pixel clock.
- rst_b  in  1  asynchronous, active-low reset.
- en  in  1  run request.
- reg_wea  in  1  register write strobe.
- reg_addra  in  RW  register address.
- reg_wdata  in  RD  register write data.
- vvalid  out  1  frame valid; high for every cycle of active lines.
- hvalid  out  1  pixel valid.
- dout  out  DW  pixel data; 0 when hvalid=0.
- frame_done  out  1  one-cycle pulse on the last cycle of each frame.

## Operation
- Counters: hcnt 0..H_ACT+H_BLANK-1 and vcnt 0..V_ACT+V_BLANK-1. hcnt wraps and increments vcnt; vcnt wraps to 0 at end of frame.
- States:
  - IDLE: counters held at 0; all outputs 0.
  - RUN: counters advance every cycle.
- Transitions:
  - IDLE→RUN when en=1 is sampled.
  - RUN→IDLE only at the frame wrap with en=0. Deasserting en mid-frame always completes the current frame.
  - RUN→RUN at the frame wrap with en=1; the next frame is back-to-back, with no gap.
- Outputs (registered) in RUN:
  - vvalid = (vcnt < V_ACT).
  - hvalid = vvalid && (hcnt < H_ACT).
  - frame_done = 1 when hcnt and vcnt are both at their maximum.
- Registers (written when reg_wea=1; unmatched addresses are ignored):
  - BASE_ADDR+0: pattern select, bits [1:0].
  - BASE_ADDR+1: constant value.
- Shadowing: both registers load into shadow copies at frame start (hcnt=0, vcnt=0, including the IDLE→RUN entry). Writes made mid-frame never alter the current frame.
- Patterns (shadow select), when hvalid=1:
  - 0: dout = hcnt[DW-1:0].
  - 1: dout = (hcnt + vcnt) mod 2^DW.
  - 2: dout = constant, zero-extended or truncated to DW.
  - 3: see Configuration.
- Reset values:
  - Outputs: vvalid=0, hvalid=0, dout=0, frame_done=0.
  - Registers and shadows: 0. State: IDLE.
- Reset is asynchronous. Asserting rst_b mid-frame forces all outputs to 0 immediately; there is no partial-frame completion.

## Timing
- The edge that samples en=1 in IDLE moves the state to RUN with hcnt=vcnt=0. Output for pixel (0,0) appears at the following edge: a 1-cycle output latency from counter to pins.
- vvalid, hvalid, dout and frame_done are mutually aligned, all registered, with no combinational path from inputs.
- A register write at edge k is visible in the shadow no earlier than the next frame-start edge after k. A write and a frame start on the same edge: the new value is taken.
- Frame period = (H_ACT+H_BLANK)×(V_ACT+V_BLANK) cycles. vvalid is high for V_ACT×(H_ACT+H_BLANK) cycles.

## Configuration
- Macro: SENSOR_TX_PRBS_EN.
- Defined: pattern 3 outputs a PRBS.
  - 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
  - Reseeded to 16'hACE1 at each frame start.
  - Advances only on hvalid cycles.
  - dout = lfsr[DW-1:0] for DW≤16.
- Undefined: no LFSR logic is built; pattern 3 behaves exactly as pattern 0.

## Test plan
Parameters for all scenarios: H_ACT=8, H_BLANK=4, V_ACT=3, V_BLANK=2 (60-cycle frame).
- Reset and idle: rst_b released, en=0 for 100 cycles -> all outputs stay 0.
- Ramp timing: en=1 held -> per line, hvalid high for 8 cycles with dout=0..7, then low for 4; vvalid high for 36 cycles, then low for 24; frame_done pulses every 60 cycles; the next frame starts on the following cycle.
- Pattern shadow: write BASE+1=8'hA5 and BASE+0=2 mid-frame -> remainder of the frame stays ramp; next frame has all active dout=8'hA5.
- Pattern 1: select 1 -> line 2 emits dout=2..9.
- Graceful stop: drop en at vvalid's 10th cycle -> frame completes (frame_done seen), then outputs stay 0. Assert rst_b=0 mid-frame -> outputs 0 within the same cycle.
- PRBS (macro defined): select 3 -> first pixel = 8'hE1, 24 pixels match the reference LFSR, and the sequence restarts identically in the next frame. Macro undefined: output equals pattern 0.
